// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// -----------------------------------------------------------------------------
// Instruction queue between the F stage and the D-stage field decoder of the
// pipelined MIPS core. It buffers up to DEPTH fetched (instr, pc) pairs behind
// valid/ready handshakes on both sides. The head entry is presented already
// split into MIPS fields. A synchronous flush clears the queue on a
// branch/jump redirect.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   PC_W   width of the stored PC
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               synchronous queue clear (redirect)
//   in_valid/in_ready   F-stage handshake; in_instr/in_pc carry the word
//   out_valid/out_ready D-stage handshake (out_ready = !stall)
//   out_instr, out_pc   raw head instruction and its PC
//   op, rsad, rtad, rdad, shamt, func, imm16, imm26, b_func
//                       head instruction fields (all zero when !out_valid)
//   is_nop              head valid and head instruction == 0
//   count               registered occupancy
//
// Build option:
//   INSTR_QUEUE_BYPASS_EN  When this is defined, a word offered to an empty
//                          queue is presented on the outputs in the same
//                          cycle. If the D stage takes it in that cycle, the
//                          word is never written to the queue.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               op,
  output logic [4:0]               rsad,
  output logic [4:0]               rtad,
  output logic [4:0]               rdad,
  output logic [4:0]               shamt,
  output logic [5:0]               func,
  output logic [15:0]              imm16,
  output logic [25:0]              imm26,
  output logic [4:0]               b_func,
  output logic                     is_nop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]     r_instr_mem [DEPTH];
  logic [PC_W-1:0] r_pc_mem    [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  logic [31:0]     w_head_instr;
  logic [PC_W-1:0] w_head_pc;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != FULL_COUNT);

`ifdef INSTR_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that the D stage takes at once is never written.
  assign w_push = in_valid && in_ready && !flush && !(w_bypass && out_ready);
  assign w_pop  = !w_empty && out_ready;

  assign w_out_valid = !w_empty || w_bypass;

  always_comb begin
    w_head_instr = '0;
    w_head_pc    = '0;
    if (w_bypass) begin
      w_head_instr = in_instr;
      w_head_pc    = in_pc;
    end else if (!w_empty) begin
      w_head_instr = r_instr_mem[r_rd_ptr];
      w_head_pc    = r_pc_mem[r_rd_ptr];
    end
  end

  // Storage needs no reset: every slot is written before count exposes it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = w_out_valid;
  assign out_instr = w_head_instr;
  assign out_pc    = w_head_pc;
  assign op        = w_head_instr[31:26];
  assign rsad      = w_head_instr[25:21];
  assign rtad      = w_head_instr[20:16];
  assign rdad      = w_head_instr[15:11];
  assign shamt     = w_head_instr[10:6];
  assign func      = w_head_instr[5:0];
  assign imm16     = w_head_instr[15:0];
  assign imm26     = w_head_instr[25:0];
  assign b_func    = w_head_instr[20:16];
  assign is_nop    = w_out_valid && (w_head_instr == '0);
  assign count     = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios followed by a random
// stream. A reference queue inside the bench records the words that are
// accepted. A negedge monitor compares the DUT head and status against the
// reference queue.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      op;
  logic [4:0]      rsad, rtad, rdad, shamt;
  logic [5:0]      func;
  logic [15:0]     imm16;
  logic [25:0]     imm26;
  logic [4:0]      b_func;
  logic            is_nop;
  logic [CW-1:0]   count;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .op(op), .rsad(rsad), .rtad(rtad), .rdad(rdad), .shamt(shamt), .func(func),
    .imm16(imm16), .imm26(imm26), .b_func(b_func), .is_nop(is_nop), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   m_count  = 0;
  bit   m_init   = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_bypass();
`ifdef INSTR_QUEUE_BYPASS_EN
    return (m_count == 0) && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: an occupancy counter plus a queue of accepted words.
  always @(posedge clk) begin : model
    bit push, pop, byp;
    ent_t e;
    if (reset) begin
      m_count = 0;
      exp_q.delete();
      m_init = 1;
    end else if (m_init) begin
      if (flush) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        byp  = f_bypass();
        push = in_valid && (m_count != DEPTH) && !(byp && out_ready);
        pop  = (m_count != 0) && out_ready;
        if (push) begin
          e.instr = in_instr;
          e.pc    = in_pc;
          exp_q.push_back(e);
        end
        m_count = m_count + int'(push) - int'(pop);
      end
    end
  end

  // Monitor: compares status and the head against the reference every cycle.
  // It retires the head entry when the D stage takes it.
  always @(negedge clk) begin : monitor
    bit   byp, ev;
    ent_t e;
    if (m_init) begin
      byp = f_bypass();
      ev  = (m_count != 0) || byp;
      chk("count", 64'(count), 64'(m_count));
      chk("in_ready", 64'(in_ready), 64'(m_count != DEPTH));
      chk("out_valid", 64'(out_valid), 64'(ev));
      e = '0;
      if (byp) begin
        e.instr = in_instr;
        e.pc    = in_pc;
      end else if (m_count != 0) begin
        if (exp_q.size() == 0) chk("sb_nonempty", 64'(0), 64'(1));
        else e = exp_q[0];
      end
      chk("out_instr", 64'(out_instr), 64'(e.instr));
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("op", 64'(op), 64'(e.instr >> 26));
      chk("rsad", 64'(rsad), 64'((e.instr >> 21) & 32'h1f));
      chk("rtad", 64'(rtad), 64'((e.instr >> 16) & 32'h1f));
      chk("rdad", 64'(rdad), 64'((e.instr >> 11) & 32'h1f));
      chk("shamt", 64'(shamt), 64'((e.instr >> 6) & 32'h1f));
      chk("func", 64'(func), 64'(e.instr & 32'h3f));
      chk("imm16", 64'(imm16), 64'(e.instr & 32'hffff));
      chk("imm26", 64'(imm26), 64'(e.instr & 32'h3ff_ffff));
      chk("b_func", 64'(b_func), 64'((e.instr >> 16) & 32'h1f));
      chk("is_nop", 64'(is_nop), 64'(ev && (e.instr == 32'h0)));
      if (!byp && m_count != 0 && out_ready && exp_q.size() != 0) exp_q.delete(0);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] p,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0]     w;
    logic [PC_W-1:0] pc_next;
    bit              hold;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    at_neg();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_op", 64'(op), 64'(0));

    // lw $2,4($1) decode
    drive(1, 32'h8C22_0004, 32'h3000, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    at_neg();
    chk("lw_valid", 64'(out_valid), 64'(1));
    chk("lw_op", 64'(op), 64'(6'h23));
    chk("lw_rs", 64'(rsad), 64'(1));
    chk("lw_rt", 64'(rtad), 64'(2));
    chk("lw_imm16", 64'(imm16), 64'(16'h0004));
    chk("lw_pc", 64'(out_pc), 64'(32'h3000));
    chk("lw_count", 64'(count), 64'(1));

    // Fill to DEPTH, then offer a 5th word
    for (int i = 1; i < DEPTH; i++) drive(1, 32'h2000_0000 + 32'(i), 32'h3000 + 32'(4*i), 0, 0);
    drive(1, 32'hDEAD_BEEF, 32'h4000, 0, 0);
    at_neg();
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    drive(1, 32'hDEAD_BEEF, 32'h4000, 1, 0);
    at_neg();
    chk("pop_same_cycle_in_ready", 64'(in_ready), 64'(0));
    drive(0, 32'h0, 32'h0, 0, 0);
    at_neg();
    chk("after_pop_count", 64'(count), 64'(DEPTH - 1));
    chk("after_pop_in_ready", 64'(in_ready), 64'(1));
    chk("after_pop_head_pc", 64'(out_pc), 64'(32'h3004));

    // Mid-stream reset with count=3
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    at_neg();
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_pc", 64'(out_pc), 64'(0));

    // Steady push+pop at count=2 across pointer wrap
    drive(1, 32'h0000_1020, 32'h3000, 0, 0);
    drive(1, 32'h0000_1021, 32'h3004, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h0000_1022 + 32'(k), 32'h3008 + 32'(4*k), 1, 0);
      at_neg();
      chk("steady_count", 64'(count), 64'(2));
      chk("steady_pc", 64'(out_pc), 64'(32'h3000 + 32'(4*k)));
    end
    drive(1, 32'h0000_2000, 32'h5000, 0, 0);

    // Flush with a concurrent push
    drive(1, 32'h0000_3000, 32'h5004, 0, 1);
    at_neg();
    chk("flush_cycle_count", 64'(count), 64'(3));
    chk("flush_cycle_valid", 64'(out_valid), 64'(1));
    drive(0, 32'h0, 32'h0, 0, 0);
    at_neg();
    chk("post_flush_count", 64'(count), 64'(0));
    chk("post_flush_valid", 64'(out_valid), 64'(0));

    // bltz offered to an empty queue with out_ready=1
    drive(1, 32'h0440_0003, 32'h6000, 1, 0);
    at_neg();
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(out_valid), 64'(1));
    chk("byp_op", 64'(op), 64'(1));
    chk("byp_b_func", 64'(b_func), 64'(0));
    chk("byp_imm16", 64'(imm16), 64'(3));
`else
    chk("nobyp_valid", 64'(out_valid), 64'(0));
`endif
    drive(0, 32'h0, 32'h0, 0, 0);
    at_neg();
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_next_count", 64'(count), 64'(0));
`else
    chk("nobyp_next_count", 64'(count), 64'(1));
`endif
    drive(0, 32'h0, 32'h0, 1, 0);

    // Random stream; a word refused by a full queue is held stable.
    pc_next = 32'h7000;
    hold    = 1'b0;
    w       = '0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        w       = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        pc_next = pc_next + 32'd4;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      in_instr  = w;
      in_pc     = pc_next;
      out_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      hold      = in_valid && (m_count == DEPTH) && !flush && !reset;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction queue between the F stage and the D-stage field decoder of the pipelined MIPS core.
- Buffers up to DEPTH fetched (instr, pc) pairs with valid/ready handshakes on both sides.
- Presents the head entry already split into MIPS fields: op, func, rs, rt, rd, shamt, imm16, imm26, b_func.
- Supports synchronous flush on branch/jump redirect. Decouples fetch from D-stage stalls.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PC_W, 32, width of the stored PC.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear (redirect).
- in_valid  input  1  F stage offers in_instr/in_pc.
- in_ready  output  1  queue accepts this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry valid.
- out_ready  input  1  D stage consumes head (= !stall).
- out_instr  output  32  raw head instruction.
- out_pc  output  PC_W  head PC.
- op  output  6  head [31:26].
- rsad  output  5  head [25:21].
- rtad  output  5  head [20:16].
- rdad  output  5  head [15:11].
- shamt  output  5  head [10:6].
- func  output  6  head [5:0].
- imm16  output  16  head [15:0].
- imm26  output  26  head [25:0].
- b_func  output  5  head [20:16] (REGIMM branch selector).
- is_nop  output  1  out_valid && head instr == 32'h0.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: DEPTH×(32+PC_W) storage, rd_ptr, wr_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), registered count.
- Reset: rd_ptr=wr_ptr=0, count=0. Storage contents need no reset.
- Output values in reset: out_valid=0, in_ready=1, all field outputs, out_instr, out_pc and is_nop = 0.
- in_ready = (count != DEPTH). Depends only on registered count; a same-cycle pop does not free space.
- push = in_valid && in_ready. Write at wr_ptr, wr_ptr+1.
- out_valid = (count != 0).
- pop = out_valid && out_ready. rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither.
- Field outputs are combinational from the storage entry at rd_ptr, with no added latency.
- When out_valid=0, all field outputs, out_instr and out_pc are forced to 0.
- Latency: a word pushed into an empty queue appears on the outputs the next cycle.
- Full: in_ready=0, so in_valid is ignored; a pop still proceeds and in_ready rises the next cycle.
- Empty: out_ready is ignored and pointers do not move.
- Simultaneous push and pop at 0<count<DEPTH: both occur and count holds.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Priority: reset > flush > push/pop.
- Flush: next cycle rd_ptr=wr_ptr=0, count=0. Any push or pop in the flush cycle is discarded. Outputs during the flush cycle itself reflect the pre-flush state.
- Reset or flush mid-stream: all buffered entries are lost; no partial state survives.
- The F stage must hold in_instr/in_pc stable while in_valid && !in_ready.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count==0 && in_valid && !flush: out_valid=1 and all fields, out_instr, out_pc come combinationally from in_instr/in_pc.
  - If out_ready is also 1: the word is consumed directly. No write occurs and count stays 0.
  - If out_ready is 0: the word is pushed normally.
  - is_nop follows the bypassed word.
  - count reports registered occupancy only.
- Without the macro: no combinational in→out path; empty-queue latency is 1 cycle as stated above.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, count=0, all field outputs 0. The same holds after reset is asserted mid-stream with count=3.
- Push 32'h8C22_0004 (lw $2,4($1)), pc=0x3000, out_ready=0: next cycle out_valid=1, op=6'h23, rsad=1, rtad=2, imm16=16'h0004, out_pc=0x3000, count=1.
- Push DEPTH=4 words with out_ready=0: count=4 and in_ready=0. A 5th in_valid is ignored. One pop leaves count=3, and in_ready=1 the following cycle.
- Steady push+pop for 10 cycles at count=2: count stays 2, order preserved across wrap-around, and PCs exit 0x3000, 0x3004, … in sequence.
- Queue holds 3 entries, flush=1 with in_valid=1: next cycle count=0, out_valid=0, and the flushed-cycle push is absent.
- Bypass build: empty queue, in_instr=32'h0440_0003 (bltz), in_valid=1, out_ready=1: same cycle out_valid=1, op=1, b_func=0, imm16=3; next cycle count=0. Non-bypass build: out_valid=0 in that cycle.
